// File: rtl/shift_sub_bytes.sv
`ifndef WORD_DATA_WIDTH
`define WORD_DATA_WIDTH 32
`endif

`default_nettype none

// ============================================================================
// Module      : shift_sub_bytes
// Description : Word-serial AES SubBytes + ShiftRows stage. Collects one
//               128-bit state as four 32-bit column words, then emits the
//               four transformed column words on consecutive cycles to
//               mix_columns.
// Ports       : clk                    - clock
//               rst_n                  - asynchronous active-low reset
//               word_in                - column word (byte [31:24] = row 0)
//               word_in_vld            - word_in valid
//               word_in_rdy            - stage can accept a word
//               last_round_in          - final-round flag, sampled with col 0
//               word_out_sub_bytes     - transformed column word
//               word_out_sub_bytes_vld - word_out_sub_bytes valid
//               mix_column_off         - latched last_round_in for this state
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sub_bytes #(
    parameter int NUM_COLS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [`WORD_DATA_WIDTH-1:0] word_in,
    input  logic                        word_in_vld,
    output logic                        word_in_rdy,
    input  logic                        last_round_in,
    output logic [`WORD_DATA_WIDTH-1:0] word_out_sub_bytes,
    output logic                        word_out_sub_bytes_vld,
    output logic                        mix_column_off
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_t;

    localparam logic [1:0] c_LAST_COL = 2'(NUM_COLS - 1);

    state_t                        r_state;
    logic [1:0]                    r_col_cnt;
    logic [`WORD_DATA_WIDTH-1:0]   r_buf [NUM_COLS];
    logic                          r_mix_column_off;
    logic [7:0]                    w_sub_byte [4];
    logic                          w_accept;

    // ------------------------------------------------------------------------
    // FIPS-197 forward S-box
    // ------------------------------------------------------------------------
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s;
        s = 8'h00;
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

    // Handshake is purely a function of the phase: input and output phases
    // never overlap, so ready and valid are complementary.
    assign word_in_rdy            = (r_state == ST_COLLECT);
    assign word_out_sub_bytes_vld = (r_state == ST_EMIT);
    assign mix_column_off         = r_mix_column_off;
    assign w_accept               = word_in_vld && word_in_rdy;

    // ------------------------------------------------------------------------
    // Control FSM and state buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_COLLECT;
            r_col_cnt        <= 2'd0;
            r_mix_column_off <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_buf[r_col_cnt] <= word_in;
                        if (r_col_cnt == 2'd0) begin
                            r_mix_column_off <= last_round_in;
                        end
                        if (r_col_cnt == c_LAST_COL) begin
                            r_col_cnt <= 2'd0;
                            r_state   <= ST_EMIT;
                        end else begin
                            r_col_cnt <= r_col_cnt + 2'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (r_col_cnt == c_LAST_COL) begin
                        r_col_cnt <= 2'd0;
                        r_state   <= ST_COLLECT;
                    end else begin
                        r_col_cnt <= r_col_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state   <= ST_COLLECT;
                    r_col_cnt <= 2'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // ShiftRows + SubBytes: row r of output column c comes from buffered
    // column (c + r) mod 4; the 2-bit add provides the wrap.
    // ------------------------------------------------------------------------
    for (genvar r = 0; r < 4; r++) begin : g_row
        logic [1:0] w_src_col;
        assign w_src_col     = r_col_cnt + 2'(r);
        assign w_sub_byte[r] = sbox(r_buf[w_src_col][31 - 8*r -: 8]);
    end

    // Zero when invalid so the combinational mix_columns sees a quiet bus.
    assign word_out_sub_bytes = word_out_sub_bytes_vld
                              ? {w_sub_byte[0], w_sub_byte[1], w_sub_byte[2], w_sub_byte[3]}
                              : '0;

endmodule

`default_nettype wire

// File: tb/tb_shift_sub_bytes.sv
`default_nettype none

// ============================================================================
// Module      : tb_shift_sub_bytes
// Description : Self-checking bench for shift_sub_bytes. Directed FIPS-197
//               vectors plus randomized states compared against a reference
//               built from GF(2^8) arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sub_bytes;

    logic        clk;
    logic        rst_n;
    logic [31:0] word_in;
    logic        word_in_vld;
    logic        word_in_rdy;
    logic        last_round_in;
    logic [31:0] word_out_sub_bytes;
    logic        word_out_sub_bytes_vld;
    logic        mix_column_off;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] r_sbox_ref [256];

    shift_sub_bytes #(.NUM_COLS(4)) u_dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .word_in                (word_in),
        .word_in_vld            (word_in_vld),
        .word_in_rdy            (word_in_rdy),
        .last_round_in          (last_round_in),
        .word_out_sub_bytes     (word_out_sub_bytes),
        .word_out_sub_bytes_vld (word_out_sub_bytes_vld),
        .mix_column_off         (mix_column_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: S-box from GF(2^8) inverse + affine
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // State as a 4x4 byte matrix st[row][col]; output[row][col] = S(st[row][(col+row)%4]).
    function automatic logic [3:0][31:0] ref_state(input logic [3:0][31:0] w);
        logic [7:0]       st  [4][4];
        logic [3:0][31:0] out;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = w[c][31 - 8*r -: 8];
        for (int c = 0; c < 4; c++) begin
            out[c] = 32'h0;
            for (int r = 0; r < 4; r++)
                out[c][31 - 8*r -: 8] = r_sbox_ref[st[r][(c + r) % 4]];
        end
        return out;
    endfunction

    // ---------------- stimulus helpers (entered and left on a negedge)
    task automatic put_word(input logic [31:0] w, input logic lro);
        int n;
        n = 0;
        word_in       = w;
        word_in_vld   = 1'b1;
        last_round_in = lro;
        while (!word_in_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rdy_wait_timeout", {31'b0, word_in_rdy}, 32'd1);
        @(negedge clk);
        word_in_vld = 1'b0;
    endtask

    task automatic gap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check("gap_vld", {31'b0, word_out_sub_bytes_vld}, 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic check_emit(input logic [3:0][31:0] exp, input logic mco, input logic hold);
        if (hold) begin
            word_in     = 32'h0;
            word_in_vld = 1'b1;
        end
        for (int c = 0; c < 4; c++) begin
            check($sformatf("emit_vld[%0d]", c), {31'b0, word_out_sub_bytes_vld}, 32'd1);
            check($sformatf("emit_rdy[%0d]", c), {31'b0, word_in_rdy}, 32'd0);
            check($sformatf("emit_word[%0d]", c), word_out_sub_bytes, exp[c]);
            check($sformatf("emit_mco[%0d]", c), {31'b0, mix_column_off}, {31'b0, mco});
            @(negedge clk);
        end
        word_in_vld = 1'b0;
        check("post_emit_vld", {31'b0, word_out_sub_bytes_vld}, 32'd0);
        check("post_emit_rdy", {31'b0, word_in_rdy}, 32'd1);
        check("post_emit_word", word_out_sub_bytes, 32'h0);
    endtask

    task automatic send_state(input logic [3:0][31:0] w, input logic lro, input int gaps);
        for (int c = 0; c < 4; c++) begin
            put_word(w[c], lro);
            if (c < 3) gap(gaps);
        end
    endtask

    task automatic reset_now(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_vld"},  {31'b0, word_out_sub_bytes_vld}, 32'd0);
        check({tag, "_word"}, word_out_sub_bytes, 32'h0);
        check({tag, "_rdy"},  {31'b0, word_in_rdy}, 32'd1);
        check({tag, "_mco"},  {31'b0, mix_column_off}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0][31:0] appb_in;
    logic [3:0][31:0] appb_out;
    logic [3:0][31:0] v_in;
    logic [3:0][31:0] v_exp;
    logic [3:0]       v_lro;

    initial begin
        for (int i = 0; i < 256; i++) r_sbox_ref[i] = sbox_calc(8'(i));

        appb_in  = {32'he9f84808, 32'h9ac68d2a, 32'ha0f4e22b, 32'h193de3be};
        appb_out = {32'h1e2798e5, 32'hb84111f1, 32'he0b452ae, 32'hd4bf5d30};

        rst_n         = 1'b0;
        word_in       = 32'h0;
        word_in_vld   = 1'b0;
        last_round_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vld",  {31'b0, word_out_sub_bytes_vld}, 32'd0);
        check("rst_word", word_out_sub_bytes, 32'h0);
        check("rst_rdy",  {31'b0, word_in_rdy}, 32'd1);
        check("rst_mco",  {31'b0, mix_column_off}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 App. B round 1, back-to-back
        send_state(appb_in, 1'b0, 0);
        check_emit(appb_out, 1'b0, 1'b0);

        // all-zero state, final round
        send_state('0, 1'b1, 0);
        check_emit({4{32'h63636363}}, 1'b1, 1'b0);

        // gapped input
        send_state(appb_in, 1'b0, 3);
        check_emit(appb_out, 1'b0, 1'b0);

        // input held valid through EMIT, then two back-to-back states
        send_state(appb_in, 1'b0, 0);
        check_emit(appb_out, 1'b0, 1'b1);
        send_state({4{32'h00530000}}, 1'b0, 0);
        check_emit({4{32'h63ed6363}}, 1'b0, 1'b1);
        send_state(appb_in, 1'b1, 0);
        check_emit(appb_out, 1'b1, 1'b0);

        // reset after two accepted words
        put_word(appb_in[0], 1'b1);
        put_word(appb_in[1], 1'b1);
        reset_now("rst_collect");
        for (int c = 0; c < 3; c++) begin
            put_word(appb_in[c], 1'b0);
            gap(1);
        end
        put_word(appb_in[3], 1'b0);
        check_emit(appb_out, 1'b0, 1'b0);

        // reset during EMIT cycle 1
        send_state(appb_in, 1'b1, 0);
        check("emit0_word", word_out_sub_bytes, appb_out[0]);
        @(negedge clk);
        reset_now("rst_emit");
        gap(3);
        send_state(appb_in, 1'b0, 1);
        check_emit(appb_out, 1'b0, 1'b0);

        // randomized states; mix_column_off follows column 0 only
        for (int t = 0; t < 25; t++) begin
            for (int c = 0; c < 4; c++) begin
                v_in[c]  = $urandom;
                v_lro[c] = 1'($urandom_range(0, 1));
            end
            v_exp = ref_state(v_in);
            for (int c = 0; c < 4; c++) begin
                put_word(v_in[c], v_lro[c]);
                if (c < 3) gap($urandom_range(0, 2));
            end
            check_emit(v_exp, v_lro[0], 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) gap(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
